// File: rtl/tdm_demux4.sv
// tdm_demux4 -- four-slot time-division demultiplexer.
//
// A serial stream of W-bit beats, framed by a sync marker on slot 0, is
// unpacked into four parallel channels. Slots 0..2 are held in shadow
// registers while the frame is in progress. The fourth beat commits the
// whole frame to q0..q3 in one edge and raises a one-cycle frame_valid.
// Framing violations raise a one-cycle frame_err instead.
//
// Handshake: a beat (din plus sync) is accepted on every rising edge where
// din_valid=1. There is no back-pressure. Cycles with din_valid=0 are gaps
// and leave all state untouched. frame_valid and frame_err are registered
// strobes that are high for exactly one cycle after the edge that caused them.
//
// state_dbg exposes the framer state for external checkers:
// 0 = IDLE (unsynchronised), 1 = RUN (synchronised).

module tdm_demux4 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         sync,
  output logic [W-1:0] q0,
  output logic [W-1:0] q1,
  output logic [W-1:0] q2,
  output logic [W-1:0] q3,
  output logic         frame_valid,
  output logic         frame_err,
  output logic [1:0]   s,
  output logic         state_dbg
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   s_q, s_d;

  logic [W-1:0] sh0_q, sh1_q, sh2_q;
  logic [W-1:0] q0_q, q1_q, q2_q, q3_q;
  logic         fv_q, fe_q;

  // Datapath strobes decoded from the current state and the accepted beat.
  logic         wr_sh0;
  logic         wr_sh1;
  logic         wr_sh2;
  logic         commit;
  logic         err;

  // State register and slot counter; both only move on accepted beats.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      s_q     <= 2'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
    end
  end

  // Next-state logic: synchronise on sync, drop back to IDLE on a lost slot 0.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    if (din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          // Beats without sync are discarded silently while unsynchronised.
          if (sync) begin
            state_d = ST_RUN;
            s_d     = 2'd1;
          end
        end
        ST_RUN: begin
          if (sync) begin
            // A sync beat always starts a new frame, early or on time.
            s_d = 2'd1;
          end else if (s_q == 2'd0) begin
            // Slot 0 arrived without its marker: lose lock.
            state_d = ST_IDLE;
            s_d     = 2'd0;
          end else begin
            // Slots 1..3; slot 3 wraps the counter back to 0.
            s_d = s_q + 2'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          s_d     = 2'd0;
        end
      endcase
    end
  end

  // Output decode: which shadow register loads, frame commit, framing error.
  always_comb begin
    wr_sh0 = 1'b0;
    wr_sh1 = 1'b0;
    wr_sh2 = 1'b0;
    commit = 1'b0;
    err    = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          wr_sh0 = sync;
        end
        ST_RUN: begin
          if (sync) begin
            wr_sh0 = 1'b1;
            // Sync anywhere but slot 0 abandons the partial frame.
            err    = (s_q != 2'd0);
          end else begin
            unique case (s_q)
              2'd0: err    = 1'b1;
              2'd1: wr_sh1 = 1'b1;
              2'd2: wr_sh2 = 1'b1;
              2'd3: commit = 1'b1;
              default: err = 1'b0;
            endcase
          end
        end
        default: begin
          err = 1'b0;
        end
      endcase
    end
  end

  // Shadow registers for slots 0..2; never cleared on error, only overwritten.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh0_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
    end else begin
      if (wr_sh0) sh0_q <= din;
      if (wr_sh1) sh1_q <= din;
      if (wr_sh2) sh2_q <= din;
    end
  end

  // Channel outputs: the whole frame lands at once on the slot-3 beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q0_q <= '0;
      q1_q <= '0;
      q2_q <= '0;
      q3_q <= '0;
    end else if (commit) begin
      q0_q <= sh0_q;
      q1_q <= sh1_q;
      q2_q <= sh2_q;
      q3_q <= din;
    end
  end

  // One-cycle strobes; commit and err are mutually exclusive by decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q <= 1'b0;
      fe_q <= 1'b0;
    end else begin
      fv_q <= commit;
      fe_q <= err;
    end
  end

  assign q0          = q0_q;
  assign q1          = q1_q;
  assign q2          = q2_q;
  assign q3          = q3_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign s           = s_q;
  assign state_dbg   = (state_q == ST_RUN);

endmodule

// File: doc/tdm_demux4.md
# tdm_demux4

Four-slot time-division demultiplexer: the receive-side counterpart of our 4-to-1 selector datapath. It takes a single serial stream of W-bit beats framed by a slot-0 sync marker, steers beat k of each frame to output channel k, and presents all four channels together, with a one-cycle frame strobe, once the frame is complete. It sits downstream of a 4:1 time-multiplexed link and restores the parallel d[0..3] view.

## Interface
- W, 1: data width of each beat and each output channel.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  W  beat data.
- din_valid  in  1  din (and sync) are sampled on this cycle.
- sync  in  1  marks the beat as slot 0 of a frame; ignored when din_valid=0.
- q0, q1, q2, q3  out  W each  registered channel outputs, updated only on frame completion.
- frame_valid  out  1  one-cycle pulse: q0..q3 hold a new complete frame.
- frame_err  out  1  one-cycle pulse: framing violation detected.
- s  out  2  current slot index (next beat expected), registered.

## Operation
- States: IDLE (unsynchronised) and RUN (synchronised). Reset enters IDLE.
- Internal shadow registers sh0, sh1, sh2 (W bits each) hold slots 0-2 of the frame in progress.
- Counter s wraps mod 4 and advances only on accepted beats. Gaps (din_valid=0) hold all state.
- IDLE:
  - din_valid & sync: sh0<=din, s<=1, go to RUN.
  - din_valid & !sync: beat is discarded silently, with no error.
- RUN, on din_valid:
  - s=0 & sync: sh0<=din, s<=1.
  - s=0 & !sync: frame_err pulse, s stays 0, go to IDLE.
  - s in {1,2} & !sync: sh[s]<=din, s<=s+1.
  - s=3 & !sync: q0<=sh0, q1<=sh1, q2<=sh2, q3<=din; frame_valid pulse; s<=0; stay in RUN.
  - s in {1,2,3} & sync (early sync): frame_err pulse. The partial frame is discarded and q is unchanged. The beat is treated as a new slot 0: sh0<=din, s<=1, stay in RUN.
- frame_valid and frame_err are never asserted together.
- Shadow contents are not cleared on error. They are always overwritten before the next use.

## Timing
- Reset (asynchronous, immediate): q0..q3=0, frame_valid=0, frame_err=0, s=0, state=IDLE, sh0..sh2=0.
- Deasserting rst takes effect at the next rising edge. The first beat can be accepted on that edge.
- Latency: the 4th beat is sampled at edge N. q0..q3 and frame_valid are valid after edge N, and frame_valid drops after edge N+1 unless another frame completes.
- Minimum frame time is 4 cycles, so back-to-back frames give frame_valid every 4th cycle at full rate.
- frame_err is registered and asserted after the edge that sampled the offending beat, for exactly one cycle.
- Reset mid-frame: the partial frame is lost, outputs return to 0 and the state returns to IDLE.

## Test plan
- Reset, then beats 1,0,1,1 (W=1) with sync on the first beat, din_valid continuous -> s steps 1,2,3,0. One cycle after the 4th beat: q0..q3=1,0,1,1, frame_valid high for exactly 1 cycle, frame_err=0.
- Same frame with din_valid=0 for 3 cycles between beats 2 and 3 -> s holds at 2 through the gap. The identical q result and single frame_valid arrive one cycle after the last beat.
- Two back-to-back frames, 0,0,0,1 then 1,1,1,0, at full rate -> frame_valid pulses 4 cycles apart. q shows 0,0,0,1, then 1,1,1,0.
- Early sync at slot 2 (beats: sync+1, 0, sync+1, 1, 0, 1) -> frame_err pulse after the 3rd beat, q unchanged. A frame of 1,1,0,1 then completes.
- Beat without sync while IDLE, then a missing sync at slot 0 in RUN after a good frame -> first beat: no err, s stays 0. Second case: frame_err pulse, return to IDLE, subsequent non-sync beats ignored.
- Assert rst after 2 beats of a frame -> all outputs 0 immediately. A following full frame decodes correctly with no frame_err.
